// File: rtl/pipelined_prefix_addsub.sv
// Pipelined Kogge-Stone prefix adder/subtractor with valid/ready flow control.
// The prefix levels are split evenly across PIPE register stages. The last stage
// resolves carries and flags into the output register. One global advance enable
// moves the whole pipe, bubbles included, so stalls never reorder or drop results.
module pipelined_prefix_addsub #(
    parameter int N    = 32,
    parameter int PIPE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);
    localparam int L  = $clog2(N);
    // Intermediate register count (PIPE-1). Keep at least one element so the arrays stay legal when PIPE=1.
    localparam int RS = (PIPE > 1) ? PIPE - 1 : 1;

    logic [N-1:0] w_b;
    logic [N-1:0] w_p0;
    logic [N-1:0] w_g0;
    logic         w_c0;
    logic         w_adv;

    // Subtraction is x + ~y + 1, so cin is replaced by a forced carry-in.
    assign w_b  = sub ? ~y : y;
    assign w_p0 = x ^ w_b;
    assign w_g0 = x & w_b;
    assign w_c0 = sub | cin;

    // Inter-stage registers. Index s holds the output of combinational stage s.
    logic         r_v   [RS];
    logic [N-1:0] r_p   [RS];
    logic [N-1:0] r_g   [RS];
    logic [N-1:0] r_pp  [RS];
    logic         r_c0  [RS];
    logic         r_xm  [RS];
    logic         r_bm  [RS];

    // Combinational result of each stage, ready to be registered.
    logic         w_v   [PIPE];
    logic [N-1:0] w_p   [PIPE];
    logic [N-1:0] w_g   [PIPE];
    logic [N-1:0] w_pp  [PIPE];
    logic         w_c0s [PIPE];
    logic         w_xm  [PIPE];
    logic         w_bm  [PIPE];

    logic [N:0]   w_c;
    logic [N-1:0] w_sum;
    logic         w_cout;
    logic         w_ovf;
    logic         w_zero;

    logic         r_ov;
    logic [N-1:0] r_sum;
    logic         r_cout;
    logic         r_ovf;
    logic         r_zero;

    // Per-stage prefix levels: stage s applies levels floor(s*L/PIPE)+1 .. floor((s+1)*L/PIPE).
    always_comb begin
        logic [N-1:0] w_tg;
        logic [N-1:0] w_tpp;
        logic [N-1:0] w_ng;
        logic [N-1:0] w_npp;
        int           d;
        w_tg  = '0;
        w_tpp = '0;
        w_ng  = '0;
        w_npp = '0;
        d     = 0;
        for (int s = 0; s < PIPE; s++) begin
            if (s == 0) begin
                w_v[s]   = in_valid;
                w_p[s]   = w_p0;
                w_tg     = w_g0;
                w_tpp    = w_p0;
                w_c0s[s] = w_c0;
                w_xm[s]  = x[N-1];
                w_bm[s]  = w_b[N-1];
            end else begin
                w_v[s]   = r_v[(s > 0) ? s - 1 : 0];
                w_p[s]   = r_p[(s > 0) ? s - 1 : 0];
                w_tg     = r_g[(s > 0) ? s - 1 : 0];
                w_tpp    = r_pp[(s > 0) ? s - 1 : 0];
                w_c0s[s] = r_c0[(s > 0) ? s - 1 : 0];
                w_xm[s]  = r_xm[(s > 0) ? s - 1 : 0];
                w_bm[s]  = r_bm[(s > 0) ? s - 1 : 0];
            end
            for (int lvl = 1; lvl <= L; lvl++) begin
                if (lvl > (s * L) / PIPE && lvl <= ((s + 1) * L) / PIPE) begin
                    d     = 1 << (lvl - 1);
                    w_ng  = w_tg;
                    w_npp = w_tpp;
                    for (int i = 0; i < N; i++) begin
                        if (i >= d) begin
                            w_ng[i]  = w_tg[i] | (w_tpp[i] & w_tg[i-d]);
                            w_npp[i] = w_tpp[i] & w_tpp[i-d];
                        end
                    end
                    w_tg  = w_ng;
                    w_tpp = w_npp;
                end
            end
            w_g[s]  = w_tg;
            w_pp[s] = w_tpp;
        end
    end

    // Carry resolution from the fully combined group generate/propagate and c0.
    always_comb begin
        w_c    = '0;
        w_c[0] = w_c0s[PIPE-1];
        for (int i = 0; i < N; i++) begin
            w_c[i+1] = w_g[PIPE-1][i] | (w_pp[PIPE-1][i] & w_c0s[PIPE-1]);
        end
    end

    assign w_sum  = w_p[PIPE-1] ^ w_c[N-1:0];
    assign w_cout = w_c[N];
    assign w_ovf  = (w_xm[PIPE-1] == w_bm[PIPE-1]) && (w_sum[N-1] != w_xm[PIPE-1]);
    assign w_zero = ~|w_sum;

    assign w_adv    = ~r_ov | out_ready;
    assign in_ready = rst_n & w_adv;

    // Whole pipe advances together, or holds together, under the single advance enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < RS; s++) begin
                r_v[s]  <= 1'b0;
                r_p[s]  <= '0;
                r_g[s]  <= '0;
                r_pp[s] <= '0;
                r_c0[s] <= 1'b0;
                r_xm[s] <= 1'b0;
                r_bm[s] <= 1'b0;
            end
            r_ov   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            for (int s = 0; s < PIPE - 1; s++) begin
                r_v[s]  <= w_v[s];
                r_p[s]  <= w_p[s];
                r_g[s]  <= w_g[s];
                r_pp[s] <= w_pp[s];
                r_c0[s] <= w_c0s[s];
                r_xm[s] <= w_xm[s];
                r_bm[s] <= w_bm[s];
            end
            r_ov   <= w_v[PIPE-1];
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign out_valid = r_ov;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
